// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: turn sequencer and move arbiter for the tic-tac-toe board.
// It accepts one move per rising edge of move_btn from the player to move.
// It rejects illegal moves, keeps the X/O occupancy planes, and detects a
// win or a draw.
// Optional feature: define TURN_TIMEOUT_EN to enable the per-turn timeout.
// With the feature enabled, a turn that runs TIMEOUT_CYCLES cycles passes to
// the other player.
module ttt_game_ctrl #(
    parameter int FIRST_PLAYER   = 0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_btn,
    input  logic [3:0] cell_sel,
    input  logic       new_game,
    output logic [8:0] board_x,
    output logic [8:0] board_o,
    output logic       turn,
    output logic       game_active,
    output logic       win_x,
    output logic       win_o,
    output logic       draw,
    output logic       illegal,
    output logic       timeout
);

    typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

    localparam logic FIRST_TURN = (FIRST_PLAYER != 0);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    state_t     state;
    logic       btn_q;
    logic       btn_edge;
    logic       move_ok;
    logic [8:0] sel_mask;
    logic [8:0] occupied;
    logic [8:0] mover_plane;

`ifdef TURN_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] turn_cnt;
`endif

    // True when any of the eight winning lines is fully occupied in plane p.
    function automatic logic has_line(input logic [8:0] p);
        return (p[0] & p[1] & p[2]) | (p[3] & p[4] & p[5]) | (p[6] & p[7] & p[8]) |
               (p[0] & p[3] & p[6]) | (p[1] & p[4] & p[7]) | (p[2] & p[5] & p[8]) |
               (p[0] & p[4] & p[8]) | (p[2] & p[4] & p[6]);
    endfunction

    // Decode the button edge and whether the selected cell may take a move.
    always_comb begin
        btn_edge    = move_btn & ~btn_q;
        sel_mask    = 9'd0;
        if (cell_sel <= 4'd8) begin
            sel_mask = 9'd1 << cell_sel;
        end
        occupied    = board_x | board_o;
        move_ok     = btn_edge && (sel_mask != 9'd0) && ((sel_mask & occupied) == 9'd0);
        mover_plane = turn ? board_o : board_x;
    end

    // Game state machine; all outputs are registered here.
    always_ff @(posedge clk) begin
        // Reset drops the remembered button level; new_game keeps tracking it,
        // so a move edge coinciding with new_game is consumed and discarded.
        btn_q   <= reset ? 1'b0 : move_btn;
        illegal <= 1'b0;
`ifdef TURN_TIMEOUT_EN
        timeout <= 1'b0;
`endif
        if (reset || new_game) begin
            state       <= PLAY;
            board_x     <= 9'd0;
            board_o     <= 9'd0;
            turn        <= FIRST_TURN;
            game_active <= 1'b1;
            win_x       <= 1'b0;
            win_o       <= 1'b0;
            draw        <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            turn_cnt    <= 16'd0;
`endif
        end else begin
            case (state)
                PLAY: begin
                    if (move_ok) begin
                        if (turn) begin
                            board_o <= board_o | sel_mask;
                        end else begin
                            board_x <= board_x | sel_mask;
                        end
                        state       <= CHECK;
                        game_active <= 1'b0;
                    end else begin
                        if (btn_edge) begin
                            illegal <= 1'b1;
                        end
`ifdef TURN_TIMEOUT_EN
                        // An illegal edge does not restart the turn timer.
                        if (turn_cnt == CNT_LAST) begin
                            timeout  <= 1'b1;
                            turn     <= ~turn;
                            turn_cnt <= 16'd0;
                        end else begin
                            turn_cnt <= turn_cnt + 16'd1;
                        end
`endif
                    end
                end
                CHECK: begin
                    if (has_line(mover_plane)) begin
                        if (turn) begin
                            win_o <= 1'b1;
                        end else begin
                            win_x <= 1'b1;
                        end
                        state <= DONE;
                    end else if (occupied == 9'h1FF) begin
                        draw  <= 1'b1;
                        state <= DONE;
                    end else begin
                        turn        <= ~turn;
                        state       <= PLAY;
                        game_active <= 1'b1;
`ifdef TURN_TIMEOUT_EN
                        turn_cnt    <= 16'd0;
`endif
                    end
                end
                default: begin
                    // DONE: hold everything until new_game or reset.
                end
            endcase
        end
    end

`ifndef TURN_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Turn sequencer and move arbiter for the tic-tac-toe board. It sits between the shared player move button / cell selector and the board and LED display registers. It accepts one move at a time from the player whose turn it is, rejects illegal moves, and updates the two 9-bit board planes. It also detects win or draw and asserts `game_active` low once the game ends, which gates further button input to the display path.

## Interface
Parameters:
- `FIRST_PLAYER`, default 0: player who moves first after reset or `new_game` (0 = X, 1 = O).
- `TIMEOUT_CYCLES`, default 1000: cycles allowed per turn. Used only when `TURN_TIMEOUT_EN` is defined; legal range is 2 to 2^16-1.

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `move_btn`, in, 1: move strobe, level input, synchronous to `clk`. Only its rising edge acts.
- `cell_sel`, in, 4: target cell 0..8, row-major. Cell 0 is top-left and cell 8 is bottom-right.
- `new_game`, in, 1: clears the board and starts a new game, from any state.
- `board_x`, out, 9: X occupancy, one bit per cell.
- `board_o`, out, 9: O occupancy, one bit per cell.
- `turn`, out, 1: player to move (0 = X, 1 = O).
- `game_active`, out, 1: high while moves are accepted (state PLAY).
- `win_x`, out, 1: X has won. Sticky until cleared.
- `win_o`, out, 1: O has won. Sticky until cleared.
- `draw`, out, 1: board full with no winner. Sticky until cleared.
- `illegal`, out, 1: one-cycle pulse when a move is rejected.
- `timeout`, out, 1: one-cycle pulse when a turn expires. Tied to 0 when the macro is absent.

## Operation
States are PLAY, CHECK and DONE.
- Rising edge detection: `btn_q` registers `move_btn` every cycle. An edge is `move_btn & ~btn_q`.
- PLAY, edge with `cell_sel` ≤ 8 and the cell empty in both planes:
  - Set the cell's bit in the current player's plane.
  - Go to CHECK.
- PLAY, edge with `cell_sel` ≥ 9 or the cell occupied:
  - Pulse `illegal` for 1 cycle.
  - Board, turn and state are unchanged.
- CHECK evaluates the mover's plane against 8 lines: rows {0,1,2},{3,4,5},{6,7,8}; columns {0,3,6},{1,4,7},{2,5,8}; diagonals {0,4,8},{2,4,6}.
  - Line complete: set `win_x` or `win_o` and go to DONE. `turn` is not toggled.
  - Else, `board_x | board_o` equals 9'h1FF: set `draw` and go to DONE.
  - Else: toggle `turn` and go to PLAY.
- Edges in CHECK or DONE are ignored. No `illegal` pulse is raised, and `btn_q` still tracks the button.
- `new_game` from any state:
  - Next cycle: boards are 0, flags are 0, `turn` = `FIRST_PLAYER`, state is PLAY.
  - It takes priority over a simultaneous move edge, which is discarded.
- `reset` has the same effect as `new_game` and also clears `btn_q`. It takes priority over everything.
- Reset values: boards 0, `turn` = `FIRST_PLAYER`, `game_active` 1, `win_x`/`win_o`/`draw` 0, `illegal` 0, `timeout` 0.
- Invariants: `board_x & board_o` is always 0, and at most one of `win_x`/`win_o`/`draw` is set.

## Timing
- Edge sampled at edge N:
  - Board bit visible after N+1.
  - CHECK result visible after N+2: `turn` toggled, or a flag set with `game_active` low.
- `illegal` is high during the cycle after the offending edge.
- A held `move_btn` yields exactly one move.
- Back-to-back moves need the button to fall and rise again. The minimum spacing between accepted moves is 2 cycles.
- `game_active` is registered and decoded from the state: high only in PLAY.

## Configuration
- `TURN_TIMEOUT_EN` defined:
  - A 16-bit turn counter resets to 0 on entry to PLAY, on `new_game` and on `reset`. It increments each cycle in PLAY.
  - On reaching `TIMEOUT_CYCLES - 1`: pulse `timeout` for 1 cycle, toggle `turn`, and reload the counter to 0. The board is unchanged.
  - A legal move edge in the same cycle as expiry wins, and no timeout occurs.
  - An illegal edge does not reset the counter.
- `TURN_TIMEOUT_EN` absent: no counter, `timeout` is constant 0, and a turn never expires.

## Test plan
- Reset, then X at 0, O at 3, X at 1, O at 4, X at 2:
  - `board_x` = 9'h007, `board_o` = 9'h018.
  - `win_x` = 1, `game_active` = 0 two cycles after the last edge, `turn` = 0.
- Full-board draw sequence 0,1,2,4,3,5,7,6,8:
  - `draw` = 1, `board_x` | `board_o` = 9'h1FF, no win flag.
- X plays 4, then O selects 4, then O selects 12:
  - Two `illegal` pulses.
  - `board_o` stays 0 and `turn` stays 1.
- `move_btn` held high for 10 cycles with `cell_sel` = 5:
  - One move only, `board_x` = 9'h020.
- After a win, a move edge is ignored. Then `new_game` together with a move edge:
  - All outputs return to reset values and the edge is discarded.
  - `reset` asserted in CHECK has the same result.
- With `TURN_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, idle in PLAY:
  - `timeout` pulses every 8 cycles and `turn` alternates.
  - A legal move on the expiry cycle suppresses the pulse.
